// File: rtl/hamming74_pkg.sv
// rtl/hamming74_pkg.sv - shared constants and lookup for the Hamming(7,4) decoder
//
// Codeword layout: [6:3] = {d3,d2,d1,d0}, [2:0] = {p2,p1,p0}.
// Each parity mask selects the received bits whose XOR forms one syndrome bit.
package hamming74_pkg;

    localparam int CW_W   = 7;
    localparam int DATA_W = 4;
    localparam int SYN_W  = 3;
    localparam int POS_W  = 3;

    // Field positions within the codeword
    localparam int P0_BIT   = 0;
    localparam int P1_BIT   = 1;
    localparam int P2_BIT   = 2;
    localparam int DATA_LSB = 3;
    localparam int DATA_MSB = 6;

    localparam logic [CW_W-1:0] P0_MASK = 7'b0111001;
    localparam logic [CW_W-1:0] P1_MASK = 7'b1101010;
    localparam logic [CW_W-1:0] P2_MASK = 7'b1110100;

    // Syndrome -> index of the codeword bit to invert (0 when clean).
    // The syndrome of a single flip equals the set of masks containing that bit.
    function automatic logic [POS_W-1:0] syn_to_pos(input logic [SYN_W-1:0] syn);
        logic [POS_W-1:0] pos;
        pos = '0;
        case (syn)
            3'b001:  pos = 3'd0;
            3'b010:  pos = 3'd1;
            3'b100:  pos = 3'd2;
            3'b011:  pos = 3'd3;
            3'b101:  pos = 3'd4;
            3'b111:  pos = 3'd5;
            3'b110:  pos = 3'd6;
            default: pos = 3'd0;
        endcase
        return pos;
    endfunction

endpackage

// File: rtl/hamming74_syndrome.sv
// rtl/hamming74_syndrome.sv - combinational syndrome computation and single-bit correction
//
// Ports:
//   encoded_data  in   7  received codeword
//   syndrome      out  3  {s2,s1,s0}
//   corrected     out  7  codeword with the indicated bit inverted
//   err_pos       out  3  index of the inverted bit, 0 when syndrome is 0
module hamming74_syndrome
    import hamming74_pkg::*;
(
    input  logic [CW_W-1:0]  encoded_data,
    output logic [SYN_W-1:0] syndrome,
    output logic [CW_W-1:0]  corrected,
    output logic [POS_W-1:0] err_pos
);

    logic [CW_W-1:0] flip_mask;

    assign syndrome = {^(encoded_data & P2_MASK),
                       ^(encoded_data & P1_MASK),
                       ^(encoded_data & P0_MASK)};

    assign err_pos = syn_to_pos(syndrome);

    // A zero syndrome also maps to position 0, so the flip must be gated
    // explicitly or a clean word would lose p0.
    always_comb begin
        flip_mask = '0;
        if (syndrome != '0) begin
            flip_mask = 7'b0000001 << err_pos;
        end
    end

    assign corrected = encoded_data ^ flip_mask;

endmodule

// File: rtl/hamming74_decoder.sv
// rtl/hamming74_decoder.sv - registered Hamming(7,4) decoder with link-health counters
//
// Ports:
//   clk           in   1      rising-edge clock
//   rst_n         in   1      asynchronous active-low reset
//   in_valid      in   1      encoded_data valid this cycle
//   encoded_data  in   7      received codeword
//   cnt_clr       in   1      synchronous clear of the statistics counters
//   out_valid     out  1      registered outputs valid (one cycle after acceptance)
//   decoded_data  out  4      corrected {d3,d2,d1,d0}
//   syndrome      out  3      raw syndrome {s2,s1,s0}
//   err_detected  out  1      syndrome nonzero
//   err_pos       out  3      index of corrected bit, 0 when clean
//   word_cnt      out  CNT_W  accepted words, saturating
//   corr_cnt      out  CNT_W  accepted words with nonzero syndrome, saturating
module hamming74_decoder
    import hamming74_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [CW_W-1:0]    encoded_data,
    input  logic               cnt_clr,
    output logic               out_valid,
    output logic [DATA_W-1:0]  decoded_data,
    output logic [SYN_W-1:0]   syndrome,
    output logic               err_detected,
    output logic [POS_W-1:0]   err_pos,
    output logic [CNT_W-1:0]   word_cnt,
    output logic [CNT_W-1:0]   corr_cnt
);

    logic [SYN_W-1:0] syn_c;
    logic [CW_W-1:0]  corrected_c;
    logic [POS_W-1:0] pos_c;
    logic             err_c;

    hamming74_syndrome u_syndrome (
        .encoded_data (encoded_data),
        .syndrome     (syn_c),
        .corrected    (corrected_c),
        .err_pos      (pos_c)
    );

    assign err_c = (syn_c != '0);

    // Data registers load only on accepted words, so an undriven codeword
    // during idle cycles never reaches the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            decoded_data <= '0;
            syndrome     <= '0;
            err_detected <= 1'b0;
            err_pos      <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                decoded_data <= corrected_c[DATA_MSB:DATA_LSB];
                syndrome     <= syn_c;
                err_detected <= err_c;
                err_pos      <= pos_c;
            end
        end
    end

    // Clear wins over increment; the word accepted alongside a clear is not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= '0;
            corr_cnt <= '0;
        end else if (cnt_clr) begin
            word_cnt <= '0;
            corr_cnt <= '0;
        end else if (in_valid) begin
            if (word_cnt != '1) begin
                word_cnt <= word_cnt + CNT_W'(1);
            end
            if (err_c && (corr_cnt != '1)) begin
                corr_cnt <= corr_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hamming74_decoder.sv
// tb/tb_hamming74_decoder.sv - self-checking bench for hamming74_decoder
module tb_hamming74_decoder;

    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [6:0]       encoded_data;
    logic             cnt_clr;
    logic             out_valid;
    logic [3:0]       decoded_data;
    logic [2:0]       syndrome;
    logic             err_detected;
    logic [2:0]       err_pos;
    logic [CNT_W-1:0] word_cnt;
    logic [CNT_W-1:0] corr_cnt;

    hamming74_decoder #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .encoded_data (encoded_data),
        .cnt_clr      (cnt_clr),
        .out_valid    (out_valid),
        .decoded_data (decoded_data),
        .syndrome     (syndrome),
        .err_detected (err_detected),
        .err_pos      (err_pos),
        .word_cnt     (word_cnt),
        .corr_cnt     (corr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state
    int m_valid, m_data, m_syn, m_err, m_pos, m_wc, m_cc;

    // Syndrome produced by a single flip at each codeword position
    int syn_of_pos [7] = '{1, 2, 4, 3, 5, 7, 6};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [6:0] encode(input int d);
        logic d0, d1, d2, d3;
        d0 = d[0]; d1 = d[1]; d2 = d[2]; d3 = d[3];
        return {d3, d2, d1, d0, d1 ^ d2 ^ d3, d0 ^ d2 ^ d3, d0 ^ d1 ^ d2};
    endfunction

    // Nearest-codeword decode: search all 16 codewords for minimum distance.
    task automatic ref_decode(input logic [6:0] cw, output int d, output int s, output int p);
        int best_dist;
        logic [6:0] e;
        best_dist = 8;
        d = 0;
        for (int k = 0; k < 16; k++) begin
            if ($countones(cw ^ encode(k)) < best_dist) begin
                best_dist = $countones(cw ^ encode(k));
                d = k;
            end
        end
        e = cw ^ encode(d);
        s = 0;
        p = 0;
        for (int i = 0; i < 7; i++) begin
            if (e[i]) begin
                p = i;
                s = syn_of_pos[i];
            end
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_data = 0; m_syn = 0; m_err = 0; m_pos = 0; m_wc = 0; m_cc = 0;
    endtask

    task automatic model_step(input logic v, input logic [6:0] cw, input logic clr);
        int d, s, p;
        ref_decode(cw, d, s, p);
        m_valid = v ? 1 : 0;
        if (v) begin
            m_data = d; m_syn = s; m_pos = p; m_err = (s != 0) ? 1 : 0;
        end
        if (clr) begin
            m_wc = 0; m_cc = 0;
        end else if (v) begin
            if (m_wc < CNT_MAX) m_wc++;
            if (s != 0 && m_cc < CNT_MAX) m_cc++;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".out_valid"},    out_valid,    m_valid);
        chk({tag, ".decoded_data"}, decoded_data, m_data);
        chk({tag, ".syndrome"},     syndrome,     m_syn);
        chk({tag, ".err_detected"}, err_detected, m_err);
        chk({tag, ".err_pos"},      err_pos,      m_pos);
        chk({tag, ".word_cnt"},     word_cnt,     m_wc);
        chk({tag, ".corr_cnt"},     corr_cnt,     m_cc);
    endtask

    task automatic cycle(input logic v, input logic [6:0] cw, input logic clr, input string tag);
        @(negedge clk);
        in_valid     = v;
        encoded_data = v ? cw : 7'bx;
        cnt_clr      = clr;
        @(posedge clk);
        model_step(v, cw, clr);
        #1;
        check_model(tag);
    endtask

    typedef struct {
        logic [6:0] cw;
        logic [3:0] exp_data;
        logic [2:0] exp_syn;
        logic [2:0] exp_pos;
        logic       exp_err;
    } vec_t;

    vec_t vecs [4];

    initial begin
        logic [3:0] held;
        vecs[0] = '{7'b1011000, 4'b1011, 3'b000, 3'd0, 1'b0};
        vecs[1] = '{7'b1001000, 4'b1011, 3'b101, 3'd4, 1'b1};
        vecs[2] = '{7'b1111000, 4'b1011, 3'b111, 3'd5, 1'b1};
        vecs[3] = '{7'b1111010, 4'b1101, 3'b101, 3'd4, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; encoded_data = '0; cnt_clr = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_model("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, vecs[i].cw, 1'b0, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.tbl_data", i), decoded_data, vecs[i].exp_data);
            chk($sformatf("vec%0d.tbl_syn", i),  syndrome,     vecs[i].exp_syn);
            chk($sformatf("vec%0d.tbl_pos", i),  err_pos,      vecs[i].exp_pos);
            chk($sformatf("vec%0d.tbl_err", i),  err_detected, vecs[i].exp_err);
        end
        chk("vec.word_cnt", word_cnt, 4);
        chk("vec.corr_cnt", corr_cnt, 3);

        // Gap: outputs hold, out_valid drops
        held = decoded_data;
        cycle(1'b0, 7'b0, 1'b0, "gap0");
        cycle(1'b0, 7'b0, 1'b0, "gap1");
        chk("gap.hold_data", decoded_data, held);
        chk("gap.out_valid", out_valid, 0);

        // Exhaustive sweep after clearing counters
        cycle(1'b0, 7'b0, 1'b1, "clr");
        for (int d = 0; d < 16; d++) begin
            for (int f = -1; f < 7; f++) begin
                logic [6:0] cw;
                cw = encode(d);
                if (f >= 0) cw[f] = ~cw[f];
                cycle(1'b1, cw, 1'b0, $sformatf("sweep_d%0d_f%0d", d, f));
                chk($sformatf("sweep_d%0d_f%0d.data", d, f), decoded_data, d);
                chk($sformatf("sweep_d%0d_f%0d.syn", d, f), syndrome, (f < 0) ? 0 : syn_of_pos[f]);
            end
        end
        chk("sweep.word_cnt", word_cnt, 128);
        chk("sweep.corr_cnt", corr_cnt, 112);

        // Saturation
        for (int i = 0; i < CNT_MAX + 5; i++) begin
            cycle(1'b1, encode(i % 16) ^ 7'b0000001, 1'b0, "sat");
        end
        chk("sat.word_cnt", word_cnt, CNT_MAX);
        chk("sat.corr_cnt", corr_cnt, CNT_MAX);

        // Clear alongside an accepted word: counters 0, decode still happens
        cycle(1'b1, 7'b1001000, 1'b1, "clr_valid");
        chk("clr_valid.word_cnt", word_cnt, 0);
        chk("clr_valid.corr_cnt", corr_cnt, 0);
        chk("clr_valid.out_valid", out_valid, 1);
        chk("clr_valid.data", decoded_data, 4'b1011);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 7'($urandom), 1'($urandom_range(0, 49) == 0), "rand");
        end

        // Asynchronous reset mid-stream
        @(negedge clk);
        in_valid = 1'b1; encoded_data = 7'b1111000; cnt_clr = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst.out_valid", out_valid, 0);
        chk("arst.data",      decoded_data, 0);
        chk("arst.syn",       syndrome, 0);
        chk("arst.err",       err_detected, 0);
        chk("arst.pos",       err_pos, 0);
        chk("arst.word_cnt",  word_cnt, 0);
        chk("arst.corr_cnt",  corr_cnt, 0);
        @(posedge clk);
        #1;
        check_model("arst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        model_step(1'b1, 7'b1111000, 1'b0);
        #1;
        check_model("arst_first");
        chk("arst_first.pos", err_pos, 5);

        cycle(1'b0, 7'b0, 1'b0, "tail");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/hamming74_decoder.md
Name: hamming74_decoder

Overview:
- Registered Hamming(7,4) single-error-correcting decoder.
- Accepts one 7-bit codeword per cycle under a valid qualifier, computes a 3-bit syndrome and corrects any single-bit error.
- Presents 4 corrected data bits, the syndrome and an error position one clock later.
- Keeps saturating statistics counters for link-health monitoring.
- Sits on the receive side of a link, downstream of the matching encoder.

Parameters:
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  encoded_data is valid this cycle
- encoded_data  in  7  received codeword
- cnt_clr  in  1  synchronous clear of statistics counters
- out_valid  out  1  registered outputs are valid
- decoded_data  out  4  corrected data {d3,d2,d1,d0}
- syndrome  out  3  raw syndrome {s2,s1,s0}
- err_detected  out  1  syndrome nonzero
- err_pos  out  3  index of the corrected codeword bit (0-6); 0 when no error
- word_cnt  out  CNT_W  words decoded
- corr_cnt  out  CNT_W  words with nonzero syndrome

Behaviour:
- Codeword layout:
  - encoded_data[6:3] = d3,d2,d1,d0.
  - encoded_data[2:0] = p2,p1,p0.
- Encoder equations (decoder recomputes these):
  - p0 = d0^d1^d2
  - p1 = d0^d2^d3
  - p2 = d1^d2^d3
- Syndrome:
  - s0 = p0^d0^d1^d2
  - s1 = p1^d0^d2^d3
  - s2 = p2^d1^d2^d3
- Syndrome-to-bit map; the bit named is inverted before data extraction:
  - 000 → none
  - 001 → bit0 (p0)
  - 010 → bit1 (p1)
  - 100 → bit2 (p2)
  - 011 → bit3 (d0)
  - 101 → bit4 (d1)
  - 111 → bit5 (d2)
  - 110 → bit6 (d3)
- Parity-bit errors leave the data unchanged.
- decoded_data = corrected[6:3].
- Double-bit errors are not detectable. They produce a nonzero syndrome and a miscorrection, and are counted as corrections. This is required behaviour.
- Latency and handshake:
  - Latency is exactly 1 cycle.
  - On a clk edge with in_valid=1, all data outputs register the result and out_valid=1.
  - On an edge with in_valid=0, out_valid=0 and the data outputs hold their previous values.
- No backpressure; a new word is accepted every cycle.
- Counters:
  - word_cnt increments per accepted word.
  - corr_cnt increments per accepted word with a nonzero syndrome.
  - Both saturate at all-ones and never wrap.
  - cnt_clr has priority over increment: clear occurs on that edge and the word accepted in the same cycle is not counted.
  - cnt_clr does not affect the decode pipeline.
- Reset:
  - rst_n low asynchronously forces out_valid, decoded_data, syndrome, err_detected, err_pos, word_cnt and corr_cnt to 0.
  - Reset mid-stream discards the in-flight word.
  - First acceptance occurs on the first rising edge with rst_n high.
- X on encoded_data while in_valid=0 must not propagate to the outputs.

Decomposition:
- Package hamming74_pkg holds:
  - Codeword field positions.
  - Parity masks: P0_MASK = 7'b0111001, P1_MASK = 7'b1101010, P2_MASK = 7'b1110100 (bit i set when encoded bit i participates in s_i's XOR).
  - Syndrome-to-position lookup function.
- One combinational sub-module, hamming74_syndrome: encoded_data in; syndrome, corrected codeword and err_pos out.
- The top level adds the output registers, valid pipeline and counters.

Test Plan:
- Clean word: encoded 7'b1011000 with in_valid → next cycle decoded 1011, syndrome 000, err_detected 0, err_pos 0, corr_cnt unchanged.
- d1 error: encoded 7'b1001000 → decoded 1011, syndrome 101, err_pos 4, err_detected 1.
- d2 error: encoded 7'b1111000 → decoded 1011, syndrome 111, err_pos 5.
- Double error: encoded 7'b1111010 → syndrome 101, decoded 1101 (miscorrection), err_detected 1.
- Exhaustive sweep: all 16 data values encoded per the equations, each with no error and then with each of the 7 single-bit flips. Required per word:
  - Every word decodes to the original data.
  - Error-free words give syndrome 000.
  - Each flip gives the syndrome mapped to the flipped bit.
  - After the sweep: word_cnt=128, corr_cnt=112.
- Control:
  - in_valid gaps: out_valid drops and the data outputs hold.
  - rst_n asserted mid-stream: all outputs 0 immediately, without waiting for an edge.
  - Counters forced to saturation stay at all-ones.
  - cnt_clr together with in_valid → counters read 0 on the next cycle.
